// File: rtl/sync_updown_counter.sv
// sync_updown_counter: free-running binary up/down counter.
// Counts by one on every rising clock edge in the direction selected by 'up',
// wrapping modulo 2^WIDTH in both directions. The output is the state register
// itself, so there is no combinational path from any input to 'count'.
module sync_updown_counter #(
    parameter int unsigned           WIDTH       = 4,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             up,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    // Step the count each edge; reset forces RESET_VALUE immediately and wins over the clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RESET_VALUE;
        end else if (up) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench for sync_updown_counter: directed reset/wrap scenarios
// followed by randomized direction and reset activity, all compared against
// an arithmetic reference model of the counter.
module tb_sync_updown_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 1 << WIDTH;

    logic             clk;
    logic             reset;
    logic             up;
    logic [WIDTH-1:0] count;

    int checkCount;
    int errorCount;
    int modelCount;

    sync_updown_counter #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0)
    ) dut (
        .up    (up),
        .clk   (clk),
        .reset (reset),
        .count (count)
    );

    // 10 ns clock with rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a run that never reaches its summary
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference rule: move one step in the chosen direction, modulo 2^WIDTH
    function automatic int nextValue(input int current, input logic goUp);
        int delta;
        delta = goUp ? 1 : -1;
        return (current + delta + MODULUS) % MODULUS;
    endfunction

    // Compare one observed value against its expected value and tally the result
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0d required=%0d", tag, observed, expected);
        end
    endtask

    // Drive direction, let one rising edge pass, advance the model and check
    task automatic applyStimulus(input logic goUp, input string tag);
        up = goUp;
        @(posedge clk);
        if (reset) modelCount = 0;
        else       modelCount = nextValue(modelCount, goUp);
        #1;
        checkOutput(tag, count, modelCount[WIDTH-1:0]);
    endtask

    // Pulse reset between edges: count must clear without waiting for a clock
    task automatic asyncResetPulse(input int heldEdges, input string tag);
        #3;
        reset = 1'b1;
        modelCount = 0;
        #1;
        checkOutput(tag, count, '0);
        for (int i = 0; i < heldEdges; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), "reset_hold");
        end
        #2;
        reset = 1'b0;
    endtask

    // Directed scenarios first, then randomized traffic
    initial begin
        checkCount = 0;
        errorCount = 0;
        modelCount = 0;

        reset = 1'b1;
        up    = 1'b1;
        #1;
        checkOutput("power_up_reset", count, 4'b0000);
        #2;
        reset = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, "count_up");
            checkOutput("count_up_const", count, 4'(i));
        end

        #7;
        up = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            applyStimulus(1'b0, "count_down");
            checkOutput("count_down_const", count, 4'(i));
        end

        applyStimulus(1'b0, "down_to_zero");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, "wrap_up");
            if (i == 15) checkOutput("wrap_up_edge15", count, 4'b1111);
            if (i == 16) checkOutput("wrap_up_edge16", count, 4'b0000);
        end
        applyStimulus(1'b0, "wrap_down");
        checkOutput("wrap_down_first", count, 4'b1111);
        applyStimulus(1'b0, "wrap_down");
        checkOutput("wrap_down_second", count, 4'b1110);

        for (int i = 0; i < 20 && modelCount != 6; i++) begin
            applyStimulus(1'b1, "seek_six");
        end
        checkOutput("at_six", count, 4'b0110);
        asyncResetPulse(2, "async_reset");
        applyStimulus(1'b1, "after_reset");
        checkOutput("after_reset_const", count, 4'b0001);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, "seek_five");
        end
        checkOutput("at_five", count, 4'b0101);
        @(posedge clk);
        reset = 1'b1;
        modelCount = 0;
        #1;
        checkOutput("reset_edge_coincident", count, 4'b0000);
        #2;
        reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                asyncResetPulse(int'($urandom_range(0, 2)), "random_reset");
            end
            applyStimulus(1'($urandom_range(0, 1)), "random_step");
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
Free-running synchronous binary up/down counter with a single direction control. It counts up or down by one on every rising clock edge. It is used as a generic event/position counter and as a verification target for counter benches. Output is the registered count; there is no combinational path from inputs to the output.

Parameters:
- WIDTH, 4, counter width in bits; count spans 0 to 2^WIDTH-1.
- RESET_VALUE, 0, value loaded into count on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- up  input  1  direction: 1 = increment, 0 = decrement.
- count  output  WIDTH  current counter value, driven directly from the register.
- Positional declaration order is fixed as: up, clk, reset, count. Existing benches connect by position.

Behaviour:
- One clock; reset is asynchronous and active-high.
  - Asserting reset forces count to RESET_VALUE (default 4'b0000) immediately, with no clock edge required.
  - count holds RESET_VALUE for as long as reset is high, regardless of clk or up.
- Deassertion of reset is not gated internally. The first count change occurs on the first rising clk edge at which reset is low.
- On each rising clk edge with reset low:
  - up=1: count <= count + 1, modulo 2^WIDTH.
  - up=0: count <= count - 1, modulo 2^WIDTH.
- No enable input: the counter changes on every clock edge outside reset; it never holds.
- Wrap-around:
  - Up direction: 2^WIDTH-1 -> 0 (4'b1111 -> 4'b0000).
  - Down direction: 0 -> 2^WIDTH-1 (4'b0000 -> 4'b1111).
  - No saturation and no overflow or underflow flag.
- Latency:
  - up is sampled at the rising edge.
  - A change on up between edges takes effect at the next rising edge. There is no retroactive effect and no glitch on count.
- Direction change: the new direction applies from the value already held.
  - Example: count=4, up goes 1->0 mid-cycle; next edge gives 3.
- Reset mid-operation:
  - count goes to RESET_VALUE asynchronously at reset assertion.
  - Any clock edge during reset is ignored.
  - Counting resumes from RESET_VALUE after release.
- Reset and clock edge coincident: reset wins; count = RESET_VALUE.
- X/Z on up while reset is low: unspecified. Benches must drive up to a known value.

Test Plan:
- Power-up reset:
  - Stimulus: clk=0, reset=1, up=1 at t=0.
  - Required: count=0000 before any clock edge.
  - Release reset at t=3 (before the first edge at t=5).
- Count up:
  - Stimulus: up=1, 10 ns clock period, rising edges at 5, 15, 25, 35.
  - Required: count=1, 2, 3, 4.
- Count down:
  - Stimulus: set up=0 at t=43, rising edges at 45, 55, 65.
  - Required: count=3, 2, 1.
- Wrap-around:
  - Stimulus (up): up=1 for 16 edges from 0.
  - Required (up): reaches 1111 on edge 15, then 0000 on edge 16.
  - Stimulus (down): from 0000 with up=0.
  - Required (down): one edge gives 1111, the next gives 1110.
- Asynchronous reset mid-count:
  - Stimulus: at count=0110, pulse reset high between clock edges.
  - Required: count=0000 immediately, without a clock edge.
  - Required: holds 0000 through edges while reset is high; first edge after release gives 0001 (up=1).
- Reset/edge coincidence:
  - Stimulus: assert reset exactly at a rising edge with count=0101.
  - Required: count=0000, not 0110.
